im_loader: RTL
==============

# im_loader

Byte-stream program loader for the 8 KB instruction memory. It sits between a byte source (UART receiver or debug port) and the instruction memory's write port. It parses a framed stream, packs bytes into 32-bit instruction words and writes them sequentially starting at a word address carried in the frame. While a frame is in flight it holds the CPU in reset so that fetch never observes a partial image.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  incoming byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data this cycle.
- im_we  out  1  one-cycle instruction-memory write strobe.
- im_addr  out  11  word address [12:2] of the write.
- im_din  out  32  instruction word to write.
- cpu_hold  out  1  CPU reset request; high while a frame is active.
- done  out  1  one-cycle pulse, frame completed successfully.
- err  out  1  one-cycle pulse, frame failed the checksum.

## Operation
- Frame format: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT×4 data bytes, then CHK.
  - ADDR is a 16-bit field; bits [10:0] form the base word address and bits [15:11] are ignored.
  - CNT is a 16-bit word count.
- A byte is accepted only when in_valid && in_ready.
- States and transitions:
  - IDLE: accept bytes and discard any byte other than SYNC_BYTE. On SYNC_BYTE go to HDR.
  - HDR: accept 4 header bytes. If CNT = 0, go to CHK (or finish directly when the feature is disabled); otherwise go to DATA.
  - DATA: accept bytes big-endian (first byte goes to [31:24]). On the 4th byte go to WRITE.
  - WRITE: drive im_we for one cycle, then increment the word address and decrement the remaining count. Return to DATA, or go to CHK when the count reaches 0.
  - CHK: accept 1 byte and compare it with the running XOR of all data bytes. On match pulse done; on mismatch pulse err. Then go to IDLE.
- The word address wraps modulo 2048; the write after 2047 goes to 0.
- Writes already issued are not undone on err.
- The running checksum clears on SYNC acceptance.
- cpu_hold:
  - Rises the cycle after SYNC is accepted.
  - Stays high through the cycle in which done or err pulses.
  - Falls the cycle after that pulse.
- im_addr and im_din hold their last values when im_we is low.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1.
  - im_we = 0, im_addr = 0, im_din = 0.
  - cpu_hold = 0, done = 0, err = 0.
- in_ready is 1 in IDLE/HDR/DATA/CHK and 0 in WRITE, so there is exactly one bubble per word.
- Write latency: im_we is asserted in the cycle after the 4th byte of the word is accepted.
- Back-to-back bytes at one per cycle give one word per 5 cycles.
- done/err pulse in the cycle after CHK is accepted. For CNT = 0 without the feature, they pulse in the cycle after CNT_L is accepted.
- in_valid gaps of any length are allowed in any state; there is no timeout.
- Reset asserted mid-frame: all outputs return immediately to their reset values, no partial word is written, and no done/err pulse is issued.

## Configuration
- IM_LOADER_CHECKSUM_EN defined: the CHK byte is part of the frame and is compared as described above.
- IM_LOADER_CHECKSUM_EN undefined:
  - No CHK byte is expected.
  - done pulses in the cycle after the last WRITE cycle.
  - err is tied to 0.

## Test plan
- Frame A5 00 00 00 01 12 34 56 78 08 -> im_we once with im_addr = 0, im_din = 32'h12345678; done one cycle after 08 is accepted; cpu_hold high from the cycle after A5 through the done cycle.
- Same frame but CHK = 09 -> the write still occurs; err pulses; done stays 0.
- Bytes FF 00 A5 00 04 60 00 02 + 8 data bytes + CHK -> FF and 00 are discarded; writes go to addresses 1120 and 1121.
- Base 07FF, CNT = 2 -> writes go to addresses 2047 then 0.
- CNT = 0 -> no im_we; done after CHK = 00 (or after CNT_L when the checksum feature is disabled).
- rst_n pulled low after 2 data bytes -> no im_we, cpu_hold = 0; a following complete frame loads correctly.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: framed byte-stream loader for the 8 KB instruction memory.
// Optional checksum byte is enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [10:0] im_addr,
  output logic [31:0] im_din,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    st_idle,
    st_hdr,
    st_data,
    st_write,
    st_chk
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  hdr_idx_reg, hdr_idx_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [10:0] addr_reg, addr_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [23:0] word_reg, word_next;
  logic        im_we_reg, im_we_next;
  logic [10:0] im_addr_reg, im_addr_next;
  logic [31:0] im_din_reg, im_din_next;
  logic        cpu_hold_reg, cpu_hold_next;
  logic        done_reg, done_next;
  logic        err_pulse;
  logic        accept;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_reg, chk_next;
  logic        err_reg, err_next;
  assign err_pulse = err_reg;
`else
  assign err_pulse = 1'b0;
`endif

  assign in_ready = (state_reg != st_write);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= st_idle;
      hdr_idx_reg  <= 2'd0;
      byte_idx_reg <= 2'd0;
      addr_reg     <= 11'd0;
      cnt_reg      <= 16'd0;
      word_reg     <= 24'd0;
      im_we_reg    <= 1'b0;
      im_addr_reg  <= 11'd0;
      im_din_reg   <= 32'd0;
      cpu_hold_reg <= 1'b0;
      done_reg     <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_reg      <= 8'd0;
      err_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      hdr_idx_reg  <= hdr_idx_next;
      byte_idx_reg <= byte_idx_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      word_reg     <= word_next;
      im_we_reg    <= im_we_next;
      im_addr_reg  <= im_addr_next;
      im_din_reg   <= im_din_next;
      cpu_hold_reg <= cpu_hold_next;
      done_reg     <= done_next;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_reg      <= chk_next;
      err_reg      <= err_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    hdr_idx_next  = hdr_idx_reg;
    byte_idx_next = byte_idx_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    word_next     = word_reg;
    im_we_next    = 1'b0;
    im_addr_next  = im_addr_reg;
    im_din_next   = im_din_reg;
    cpu_hold_next = cpu_hold_reg;
    done_next     = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
    chk_next      = chk_reg;
    err_next      = 1'b0;
`endif
    // Hold drops the cycle after a completion pulse unless a new frame starts.
    if (done_reg || err_pulse) cpu_hold_next = 1'b0;

    case (state_reg)
      st_idle: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_next    = st_hdr;
          hdr_idx_next  = 2'd0;
          cpu_hold_next = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
          chk_next      = 8'd0;
`endif
        end
      end
      st_hdr: begin
        if (accept) begin
          hdr_idx_next = hdr_idx_reg + 2'd1;
          case (hdr_idx_reg)
            2'd0: addr_next[10:8] = in_data[2:0];
            2'd1: addr_next[7:0]  = in_data;
            2'd2: cnt_next[15:8]  = in_data;
            default: begin
              cnt_next[7:0] = in_data;
              byte_idx_next = 2'd0;
              if ({cnt_reg[15:8], in_data} == 16'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
                state_next = st_chk;
`else
                state_next = st_idle;
                done_next  = 1'b1;
`endif
              end else begin
                state_next = st_data;
              end
            end
          endcase
        end
      end
      st_data: begin
        if (accept) begin
          word_next     = {word_reg[15:0], in_data};
          byte_idx_next = byte_idx_reg + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          chk_next      = chk_reg ^ in_data;
`endif
          if (byte_idx_reg == 2'd3) begin
            im_we_next   = 1'b1;
            im_addr_next = addr_reg;
            im_din_next  = {word_reg, in_data};
            state_next   = st_write;
          end
        end
      end
      st_write: begin
        addr_next = addr_reg + 11'd1;
        cnt_next  = cnt_reg - 16'd1;
        if (cnt_reg == 16'd1) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_next = st_chk;
`else
          state_next = st_idle;
          done_next  = 1'b1;
`endif
        end else begin
          state_next = st_data;
        end
      end
      st_chk: begin
`ifdef IM_LOADER_CHECKSUM_EN
        if (accept) begin
          state_next = st_idle;
          if (in_data == chk_reg) done_next = 1'b1;
          else                    err_next  = 1'b1;
        end
`else
        state_next = st_idle;
`endif
      end
      default: state_next = st_idle;
    endcase
  end

  assign im_we    = im_we_reg;
  assign im_addr  = im_addr_reg;
  assign im_din   = im_din_reg;
  assign cpu_hold = cpu_hold_reg;
  assign done     = done_reg;
  assign err      = err_pulse;

endmodule
